// File: rtl/ram_monitor_pkg.sv
// Shared definitions for the UART monitor / boot controller:
// command and reply bytes, FSM state encoding and small decode helpers.
package ram_monitor_pkg;

    // Command bytes accepted in IDLE
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_READ = 8'h52;  // 'R'
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

    // Reply bytes sent back over the UART
    localparam logic [7:0] RSP_OK   = 8'h2E;  // '.'
    localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'
    localparam logic [7:0] RSP_HALT = 8'h48;  // 'H'

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ARGH   = 4'd1,
        ST_ARGL   = 4'd2,
        ST_ARGN   = 4'd3,
        ST_LDATA  = 4'd4,
        ST_WRITE  = 4'd5,
        ST_RADDR  = 4'd6,
        ST_RWAIT  = 4'd7,
        ST_RSEND  = 4'd8,
        ST_GO     = 4'd9,
        ST_RUN    = 4'd10,
        ST_TXWAIT = 4'd11,
        ST_TXGAP  = 4'd12
    } state_t;

    // Where the transmit sequence continues once a byte has gone out
    typedef enum logic [1:0] {
        NEXT_IDLE = 2'd0,  // reply finished, back to command parsing
        NEXT_READ = 2'd1,  // more dump bytes to fetch
        NEXT_OK   = 2'd2   // dump finished, send the OK reply
    } tx_next_t;

    // True for the three command bytes that take arguments
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_READ) || (b == CMD_GO);
    endfunction

endpackage

// File: rtl/ram_monitor_if.sv
// UART and program-RAM signal bundle seen by the monitor.
// master: the monitor side (drives RAM and UART tx),
// slave:  the UART/RAM side (drives rx, busy and read data).
interface ram_monitor_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic [DW-1:0] rx_byte;
    logic          received;
    logic [DW-1:0] tx_byte;
    logic          transmit;
    logic          is_transmitting;
    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_dwrite;
    logic          ram_we;
    logic [DW-1:0] ram_dread;

    modport master (
        input  rx_byte, received, is_transmitting, ram_dread,
        output tx_byte, transmit, ram_raddr, ram_waddr, ram_dwrite, ram_we
    );

    modport slave (
        output rx_byte, received, is_transmitting, ram_dread,
        input  tx_byte, transmit, ram_raddr, ram_waddr, ram_dwrite, ram_we
    );
endinterface

// File: rtl/ram_monitor_ram_uart_mux.sv
// Combinational owner mux: while the CPU runs it sees the RAM and UART
// directly; otherwise the monitor drives them and the CPU sees a busy,
// silent UART.
module ram_uart_mux #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          running,
    // monitor side
    input  logic [AW-1:0] mon_raddr,
    input  logic [AW-1:0] mon_waddr,
    input  logic [DW-1:0] mon_dwrite,
    input  logic          mon_we,
    input  logic [DW-1:0] mon_tx_byte,
    input  logic          mon_transmit,
    // CPU side
    input  logic [AW-1:0] cpu_raddr,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_dwrite,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_tx_byte,
    input  logic          cpu_transmit,
    // UART status/rx
    input  logic          uart_received,
    input  logic [DW-1:0] uart_rx_byte,
    input  logic          uart_is_transmitting,
    // muxed outputs
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_dwrite,
    output logic          ram_we,
    output logic [DW-1:0] tx_byte,
    output logic          transmit,
    output logic          cpu_is_transmitting,
    output logic          cpu_received,
    output logic [DW-1:0] cpu_rx_byte
);

    // Select the RAM/UART owner; rx data is always visible, only the strobe is gated
    always_comb begin
        ram_raddr           = mon_raddr;
        ram_waddr           = mon_waddr;
        ram_dwrite          = mon_dwrite;
        ram_we              = mon_we;
        tx_byte             = mon_tx_byte;
        transmit            = mon_transmit;
        cpu_is_transmitting = 1'b1;
        cpu_received        = 1'b0;
        cpu_rx_byte         = uart_rx_byte;
        if (running) begin
            ram_raddr           = cpu_raddr;
            ram_waddr           = cpu_waddr;
            ram_dwrite          = cpu_dwrite;
            ram_we              = cpu_we;
            tx_byte             = cpu_tx_byte;
            transmit            = cpu_transmit;
            cpu_is_transmitting = uart_is_transmitting;
            cpu_received        = uart_received;
        end
    end

endmodule

// File: rtl/ram_monitor.sv
// UART monitor / boot controller. Parses L/R/G commands from the UART,
// loads and dumps the program RAM, then hands RAM and UART to the CPU
// until it reports halted.
module ram_monitor
    import ram_monitor_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    ram_monitor_if.master bus,
    input  logic [AW-1:0] cpu_raddr,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_dwrite,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_tx_byte,
    input  logic          cpu_transmit,
    output logic          cpu_is_transmitting,
    output logic          cpu_received,
    output logic [DW-1:0] cpu_rx_byte,
    output logic          cpu_start,
    output logic [AW-1:0] cpu_startaddr,
    input  logic          cpu_halted,
    output logic          running
);

    state_t        state;
    tx_next_t      tx_next;
    logic [DW-1:0] cmd;
    logic [AW-1:0] addr;
    logic [DW:0]   cnt;          // one extra bit so a count byte of 0 can mean 256
    logic [AW-1:0] mon_raddr;
    logic [AW-1:0] mon_waddr;
    logic [DW-1:0] mon_dwrite;
    logic          mon_we;
    logic [DW-1:0] mon_tx_byte;
    logic          mon_transmit;

    localparam logic [DW:0] CNT_ONE = {{DW{1'b0}}, 1'b1};
    localparam logic [DW:0] CNT_MAX = {1'b1, {DW{1'b0}}};

    // Command FSM: argument parsing, load writes, dump reads, transmit handshake, CPU run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            tx_next       <= NEXT_IDLE;
            cmd           <= '0;
            addr          <= '0;
            cnt           <= '0;
            mon_raddr     <= '0;
            mon_waddr     <= '0;
            mon_dwrite    <= '0;
            mon_we        <= 1'b0;
            mon_tx_byte   <= '0;
            mon_transmit  <= 1'b0;
            cpu_start     <= 1'b0;
            cpu_startaddr <= '0;
            running       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.received) begin
                        cmd <= bus.rx_byte;
                        if (is_cmd(bus.rx_byte)) begin
                            state <= ST_ARGH;
                        end else begin
                            mon_tx_byte <= RSP_ERR;
                            tx_next     <= NEXT_IDLE;
                            state       <= ST_TXWAIT;
                        end
                    end
                end

                ST_ARGH: begin
                    // only the low bit(s) of the high byte reach the address
                    if (bus.received) begin
                        addr[AW-1:DW] <= bus.rx_byte[AW-DW-1:0];
                        state         <= ST_ARGL;
                    end
                end

                ST_ARGL: begin
                    if (bus.received) begin
                        addr[DW-1:0] <= bus.rx_byte;
                        if (cmd == CMD_GO) begin
                            cpu_startaddr <= {addr[AW-1:DW], bus.rx_byte};
                            cpu_start     <= 1'b1;
                            state         <= ST_GO;
                        end else begin
                            state <= ST_ARGN;
                        end
                    end
                end

                ST_ARGN: begin
                    if (bus.received) begin
                        cnt   <= (bus.rx_byte == '0) ? CNT_MAX : {1'b0, bus.rx_byte};
                        state <= (cmd == CMD_LOAD) ? ST_LDATA : ST_RADDR;
                    end
                end

                ST_LDATA: begin
                    if (bus.received) begin
                        mon_waddr  <= addr;
                        mon_dwrite <= bus.rx_byte;
                        mon_we     <= 1'b1;
                        state      <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    mon_we <= 1'b0;
                    addr   <= addr + 1'b1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_ONE) begin
                        mon_tx_byte <= RSP_OK;
                        tx_next     <= NEXT_IDLE;
                        state       <= ST_TXWAIT;
                    end else begin
                        state <= ST_LDATA;
                    end
                end

                ST_RADDR: begin
                    mon_raddr <= addr;
                    state     <= ST_RWAIT;
                end

                // the RAM registers its read address, so data is valid one cycle later
                ST_RWAIT: begin
                    state <= ST_RSEND;
                end

                ST_RSEND: begin
                    mon_tx_byte <= bus.ram_dread;
                    addr        <= addr + 1'b1;
                    cnt         <= cnt - 1'b1;
                    tx_next     <= (cnt == CNT_ONE) ? NEXT_OK : NEXT_READ;
                    state       <= ST_TXWAIT;
                end

                ST_TXWAIT: begin
                    if (!bus.is_transmitting) begin
                        mon_transmit <= 1'b1;
                        state        <= ST_TXGAP;
                    end
                end

                // one spare cycle lets the UART raise busy before it is checked again
                ST_TXGAP: begin
                    mon_transmit <= 1'b0;
                    case (tx_next)
                        NEXT_READ: state <= ST_RADDR;
                        NEXT_OK: begin
                            mon_tx_byte <= RSP_OK;
                            tx_next     <= NEXT_IDLE;
                            state       <= ST_TXWAIT;
                        end
                        default:   state <= ST_IDLE;
                    endcase
                end

                ST_GO: begin
                    cpu_start <= 1'b0;
                    running   <= 1'b1;
                    state     <= ST_RUN;
                end

                ST_RUN: begin
                    if (cpu_halted) begin
                        running     <= 1'b0;
                        mon_tx_byte <= RSP_HALT;
                        tx_next     <= NEXT_IDLE;
                        state       <= ST_TXWAIT;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ram_uart_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .running              (running),
        .mon_raddr            (mon_raddr),
        .mon_waddr            (mon_waddr),
        .mon_dwrite           (mon_dwrite),
        .mon_we               (mon_we),
        .mon_tx_byte          (mon_tx_byte),
        .mon_transmit         (mon_transmit),
        .cpu_raddr            (cpu_raddr),
        .cpu_waddr            (cpu_waddr),
        .cpu_dwrite           (cpu_dwrite),
        .cpu_we               (cpu_we),
        .cpu_tx_byte          (cpu_tx_byte),
        .cpu_transmit         (cpu_transmit),
        .uart_received        (bus.received),
        .uart_rx_byte         (bus.rx_byte),
        .uart_is_transmitting (bus.is_transmitting),
        .ram_raddr            (bus.ram_raddr),
        .ram_waddr            (bus.ram_waddr),
        .ram_dwrite           (bus.ram_dwrite),
        .ram_we               (bus.ram_we),
        .tx_byte              (bus.tx_byte),
        .transmit             (bus.transmit),
        .cpu_is_transmitting  (cpu_is_transmitting),
        .cpu_received         (cpu_received),
        .cpu_rx_byte          (cpu_rx_byte)
    );

endmodule

// File: tb/tb_ram_monitor.sv
// Directed bench for ram_monitor: a 512x8 registered-read RAM model,
// a UART transmitter model with a short busy period, and command
// sequences with hand-computed replies and RAM contents.
module tb_ram_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] cpu_raddr, cpu_waddr, cpu_startaddr;
    logic [7:0] cpu_dwrite, cpu_tx_byte, cpu_rx_byte;
    logic       cpu_we, cpu_transmit, cpu_is_transmitting, cpu_received;
    logic       cpu_start, cpu_halted, running;

    ram_monitor_if #(.AW(9), .DW(8)) bus ();

    ram_monitor #(.AW(9), .DW(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .bus                 (bus),
        .cpu_raddr           (cpu_raddr),
        .cpu_waddr           (cpu_waddr),
        .cpu_dwrite          (cpu_dwrite),
        .cpu_we              (cpu_we),
        .cpu_tx_byte         (cpu_tx_byte),
        .cpu_transmit        (cpu_transmit),
        .cpu_is_transmitting (cpu_is_transmitting),
        .cpu_received        (cpu_received),
        .cpu_rx_byte         (cpu_rx_byte),
        .cpu_start           (cpu_start),
        .cpu_startaddr       (cpu_startaddr),
        .cpu_halted          (cpu_halted),
        .running             (running)
    );

    always #5 clk = ~clk;

    // RAM model (registered read) and UART model state
    logic [7:0] mem [512];
    logic [7:0] exp_mem [512];
    logic       mem_ready = 1'b0;
    int         wr_count  = 0;
    int         busy_cnt  = 0;
    int         tx_viol   = 0;
    logic       force_busy = 1'b0;
    logic [7:0] txq [$];

    int n_tests = 0;
    int n_fail  = 0;
    int tx_base = 0;

    function automatic logic [7:0] prefill(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    // RAM: prefill on the first edge, then write port and registered read
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= prefill(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.ram_we) begin
                mem[bus.ram_waddr] <= bus.ram_dwrite;
                wr_count <= wr_count + 1;
            end
        end
        bus.ram_dread <= mem[bus.ram_raddr];
    end

    // UART transmitter: capture each strobe and stay busy for 3 cycles
    always @(posedge clk) begin
        if (bus.transmit) begin
            txq.push_back(bus.tx_byte);
            if (bus.is_transmitting) tx_viol <= tx_viol + 1;
            busy_cnt <= 3;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign bus.is_transmitting = force_busy | (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tx_at(input int k);
        if (tx_base + k < txq.size()) return txq[tx_base + k];
        return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while ((txq.size() - tx_base) < n && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(txq.size() - tx_base), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int mism;
        bus.rx_byte  = 8'h00;
        bus.received = 1'b0;
        cpu_raddr = '0; cpu_waddr = '0; cpu_dwrite = '0; cpu_we = 1'b0;
        cpu_tx_byte = '0; cpu_transmit = 1'b0; cpu_halted = 1'b0;
        for (int i = 0; i < 512; i++) exp_mem[i] = prefill(i);

        // ---- reset state ----
        repeat (3) @(negedge clk);
        bus.rx_byte  = 8'h41;
        bus.received = 1'b1;
        #1;
        check("rst_transmit", 32'(bus.transmit), 0);
        check("rst_tx_byte", 32'(bus.tx_byte), 0);
        check("rst_cpu_start", 32'(cpu_start), 0);
        check("rst_startaddr", 32'(cpu_startaddr), 0);
        check("rst_running", 32'(running), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_cpu_is_tx", 32'(cpu_is_transmitting), 1);
        check("rst_cpu_received", 32'(cpu_received), 0);
        @(negedge clk);
        bus.received = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- load 3 bytes at 0x010 ----
        tx_base = txq.size();
        w0 = wr_count;
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h10); send_gap(8'h03);
        send_gap(8'hAA); send_gap(8'hBB); send_gap(8'hCC);
        exp_mem[9'h010] = 8'hAA; exp_mem[9'h011] = 8'hBB; exp_mem[9'h012] = 8'hCC;
        wait_tx(1, "load_reply_cnt");
        check("load_reply", 32'(tx_at(0)), 32'h2E);
        check("load_writes", 32'(wr_count - w0), 3);
        check("load_m010", 32'(mem[9'h010]), 32'hAA);
        check("load_m011", 32'(mem[9'h011]), 32'hBB);
        check("load_m012", 32'(mem[9'h012]), 32'hCC);
        repeat (5) @(negedge clk);

        // ---- dump them back ----
        tx_base = txq.size();
        send_gap(8'h52); send_gap(8'h00); send_gap(8'h10); send_gap(8'h03);
        wait_tx(4, "dump3_cnt");
        check("dump3_b0", 32'(tx_at(0)), 32'hAA);
        check("dump3_b1", 32'(tx_at(1)), 32'hBB);
        check("dump3_b2", 32'(tx_at(2)), 32'hCC);
        check("dump3_ok", 32'(tx_at(3)), 32'h2E);
        repeat (5) @(negedge clk);

        // ---- address wrap 0x1FF -> 0x000 ----
        tx_base = txq.size();
        send_gap(8'h4C); send_gap(8'h01); send_gap(8'hFF); send_gap(8'h02);
        send_gap(8'h11); send_gap(8'h22);
        exp_mem[9'h1FF] = 8'h11; exp_mem[9'h000] = 8'h22;
        wait_tx(1, "wrap_reply_cnt");
        check("wrap_reply", 32'(tx_at(0)), 32'h2E);
        check("wrap_m1ff", 32'(mem[9'h1FF]), 32'h11);
        check("wrap_m000", 32'(mem[9'h000]), 32'h22);
        repeat (5) @(negedge clk);

        // ---- count 0 means 256 ----
        tx_base = txq.size();
        send_gap(8'h52); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
        wait_tx(257, "dump256_wait");
        repeat (40) @(negedge clk);
        check("dump256_cnt", 32'(txq.size() - tx_base), 257);
        mism = 0;
        for (int i = 0; i < 256; i++) if (tx_at(i) !== exp_mem[i]) mism++;
        check("dump256_data", 32'(mism), 0);
        check("dump256_ok", 32'(tx_at(256)), 32'h2E);
        repeat (5) @(negedge clk);

        // ---- run handoff ----
        send_gap(8'h47); send_gap(8'h01);
        send_byte(8'h00);
        check("go_start_pulse", 32'(cpu_start), 1);
        check("go_not_yet_running", 32'(running), 0);
        check("go_startaddr", 32'(cpu_startaddr), 32'h100);
        @(negedge clk);
        check("go_start_done", 32'(cpu_start), 0);
        check("go_running", 32'(running), 1);
        cpu_we = 1'b1; cpu_waddr = 9'h055; cpu_dwrite = 8'h77; cpu_raddr = 9'h1AB;
        cpu_tx_byte = 8'h99; cpu_transmit = 1'b1;
        bus.rx_byte = 8'h41; bus.received = 1'b1;
        #1;
        check("run_ram_we", 32'(bus.ram_we), 1);
        check("run_ram_waddr", 32'(bus.ram_waddr), 32'h055);
        check("run_ram_dwrite", 32'(bus.ram_dwrite), 32'h77);
        check("run_ram_raddr", 32'(bus.ram_raddr), 32'h1AB);
        check("run_tx_byte", 32'(bus.tx_byte), 32'h99);
        check("run_transmit", 32'(bus.transmit), 1);
        check("run_cpu_received", 32'(cpu_received), 1);
        check("run_cpu_rx_byte", 32'(cpu_rx_byte), 32'h41);
        check("run_cpu_is_tx", 32'(cpu_is_transmitting), 0);
        @(negedge clk);
        cpu_we = 1'b0; cpu_transmit = 1'b0; bus.received = 1'b0;
        exp_mem[9'h055] = 8'h77;
        check("run_cpu_write", 32'(mem[9'h055]), 32'h77);
        check("run_still_running", 32'(running), 1);
        repeat (6) @(negedge clk);
        tx_base = txq.size();
        cpu_halted = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        check("halt_running", 32'(running), 0);
        wait_tx(1, "halt_reply_cnt");
        check("halt_reply", 32'(tx_at(0)), 32'h48);
        repeat (6) @(negedge clk);

        // ---- halt outside RUN is ignored ----
        tx_base = txq.size();
        cpu_halted = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        repeat (20) @(negedge clk);
        check("stray_halt_tx", 32'(txq.size() - tx_base), 0);

        // ---- unknown byte with UART busy, dropped strobe ----
        force_busy = 1'b1;
        tx_base = txq.size();
        send_gap(8'h5A);
        repeat (50) @(negedge clk);
        send_byte(8'h52);
        repeat (46) @(negedge clk);
        check("busy_no_tx", 32'(txq.size() - tx_base), 0);
        force_busy = 1'b0;
        wait_tx(1, "err_reply_cnt");
        check("err_reply", 32'(tx_at(0)), 32'h3F);
        repeat (20) @(negedge clk);
        check("err_once", 32'(txq.size() - tx_base), 1);
        send_gap(8'h5A);
        wait_tx(2, "err2_reply_cnt");
        check("err2_reply", 32'(tx_at(1)), 32'h3F);
        repeat (6) @(negedge clk);

        // ---- async reset mid-load ----
        tx_base = txq.size();
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h20); send_gap(8'h03);
        send_gap(8'h11);
        exp_mem[9'h020] = 8'h11;
        w0 = wr_count;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_running", 32'(running), 0);
        check("arst_ram_we", 32'(bus.ram_we), 0);
        check("arst_transmit", 32'(bus.transmit), 0);
        check("arst_startaddr", 32'(cpu_startaddr), 0);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_no_writes", 32'(wr_count - w0), 0);
        check("arst_no_reply", 32'(txq.size() - tx_base), 0);
        send_gap(8'h52); send_gap(8'h00); send_gap(8'h20); send_gap(8'h03);
        wait_tx(4, "arst_dump_cnt");
        check("arst_dump_b0", 32'(tx_at(0)), 32'h11);
        check("arst_dump_b1", 32'(tx_at(1)), 32'(exp_mem[9'h021]));
        check("arst_dump_b2", 32'(tx_at(2)), 32'(exp_mem[9'h022]));
        check("arst_dump_ok", 32'(tx_at(3)), 32'h2E);
        repeat (5) @(negedge clk);

        // ---- async reset while the CPU runs ----
        send_gap(8'h47); send_gap(8'h00); send_byte(8'h00);
        @(negedge clk);
        check("run2_running", 32'(running), 1);
        #2 rst = 1'b0;
        #1;
        check("run2_arst_running", 32'(running), 0);
        check("run2_arst_cpu_is_tx", 32'(cpu_is_transmitting), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("tx_while_busy", 32'(tx_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
